// File: rtl/mux8_rr_scheduler_pkg.sv
// mux8_rr_scheduler_pkg: shared widths and types for the round-robin mux scheduler
// Provides N_REQ/SEL_W, the select type and the two-state scheduler FSM encoding.
package mux_sched_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    typedef logic [SEL_W-1:0] sel_t;
    typedef enum logic {IDLE, GRANT} sched_state_t;
endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// mux8_rr_scheduler_if: request/grant bundle between requesters and the scheduler
// master: drives req/done, observes grant/sel/busy/timeout
// slave : scheduler side, drives grant/sel/busy/timeout from req/done
interface mux8_rr_scheduler_if;
    import mux_sched_pkg::*;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    sel_t             sel;
    logic             busy;
    logic             timeout;
    modport master (output req, done, input grant, sel, busy, timeout);
    modport slave  (input req, done, output grant, sel, busy, timeout);
endinterface

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// rr_pick8: combinational round-robin pick of the first request at or after ptr
// req [7:0] in, ptr [2:0] in -> idx [2:0] winning index, any = at least one request
module rr_pick8
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output sel_t             idx,
    output logic             any
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    sel_t               off;
    // rot[k] = req[(ptr+k) mod 8], so the lowest set bit is the winner's offset from ptr
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_REQ-1:0];
    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = sel_t'(k);
    end
    assign idx = ptr + off;
    assign any = |req;
endmodule

// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin arbiter driving the select of a shared 8:1 mux
// clk, reset (async active-high); bus.slave: req/done in, grant/sel/busy/timeout out.
// Grants last 1..MAX_HOLD cycles with one idle bubble between grants.
module mux8_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int CNT_W    = $clog2(MAX_HOLD)
) (
    input logic                 clk,
    input logic                 reset,
    mux8_rr_scheduler_if.slave  bus
);
    sched_state_t     state;
    sel_t             ptr, sel_q, pick_idx;
    logic             pick_any, busy_q, timeout_q;
    logic [N_REQ-1:0] grant_q;
    logic [CNT_W-1:0] cnt;
    rr_pick8 u_pick (.req(bus.req), .ptr(ptr), .idx(pick_idx), .any(pick_any));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (pick_any) begin
                        state   <= GRANT;
                        grant_q <= N_REQ'(1) << pick_idx;
                        sel_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                    end
                end
                GRANT: begin
                    // done/withdrawal take precedence, so timeout only flags a pure forced release
                    if (bus.done || !bus.req[sel_q] || cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state     <= IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        ptr       <= sel_q + 3'd1;
                        cnt       <= '0;
                        timeout_q <= !(bus.done || !bus.req[sel_q]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler: directed plus random checks of the scheduler against a behavioural model
module tb_mux8_rr_scheduler;
    import mux_sched_pkg::*;
    localparam int MH = 4;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mux8_rr_scheduler_if bus ();
    mux8_rr_scheduler #(.MAX_HOLD(MH)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int failures = 0;
    bit m_busy, m_to;
    int m_idx, m_ptr, m_held;
    task automatic model_reset();
        m_busy = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_held = 0;
    endtask
    task automatic model_release(input bit forced);
        m_busy = 0;
        m_to = forced;
        m_ptr = (m_idx + 1) % 8;
    endtask
    task automatic model_step(input logic [7:0] r, input logic d);
        if (!m_busy) begin
            m_to = 0;
            if (r != 0) begin
                for (int i = 7; i >= 0; i--)
                    if (r[(m_ptr + i) % 8]) m_idx = (m_ptr + i) % 8;
                m_busy = 1;
                m_held = 1;
            end
        end else if (d || !r[m_idx]) begin
            model_release(0);
        end else if (m_held == MH) begin
            model_release(1);
        end else begin
            m_held++;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_model(input string tag);
        chk({tag, ".grant"}, 32'(bus.grant), m_busy ? 32'(1) << m_idx : 32'd0);
        chk({tag, ".sel"}, 32'(bus.sel), 32'(m_idx));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
        chk({tag, ".onehot0"}, 32'($onehot0(bus.grant)), 32'd1);
    endtask
    task automatic step(input string tag);
        @(posedge clk);
        model_step(bus.req, bus.done);
        #1;
        check_model(tag);
    endtask
    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;
        // async reset in the middle of a grant to 5
        bus.req = 8'h20;
        step("t1_grant");
        chk("t1_grant20", 32'(bus.grant), 32'h20);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_grant", 32'(bus.grant), 32'h0);
        chk("t1_async_sel", 32'(bus.sel), 32'h0);
        chk("t1_async_busy", 32'(bus.busy), 32'h0);
        model_reset();
        bus.req = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.req = 8'hFF;
        step("t1_ptr0");
        chk("t1_ptr0_grant", 32'(bus.grant), 32'h01);
        bus.done = 1'b1;
        step("t1_rel");
        bus.done = 1'b0;
        // single requester, done release, then ptr moves past it
        bus.req = 8'h20;
        step("t2_grant");
        chk("t2_sel5", 32'(bus.sel), 32'd5);
        bus.done = 1'b1;
        step("t2_done");
        chk("t2_idle", 32'(bus.grant), 32'h0);
        bus.done = 1'b0;
        bus.req = 8'hFF;
        step("t2_next");
        chk("t2_grant40", 32'(bus.grant), 32'h40);
        // all requesting, done every granted cycle: strict rotation with bubbles
        bus.done = 1'b1;
        for (int i = 0; i < 20; i++) step("t3_rotate");
        bus.done = 1'b0;
        bus.req = '0;
        repeat (2) step("t3_drain");
        // wrap from ptr=6 to index 0
        bus.req = 8'h20;
        step("t4_g5");
        bus.done = 1'b1;
        step("t4_rel5");
        bus.done = 1'b0;
        bus.req = 8'h03;
        step("t4_g0");
        chk("t4_grant01", 32'(bus.grant), 32'h01);
        chk("t4_sel0", 32'(bus.sel), 32'd0);
        bus.done = 1'b1;
        step("t4_rel0");
        bus.done = 1'b0;
        step("t4_g1");
        chk("t4_grant02", 32'(bus.grant), 32'h02);
        bus.req = '0;
        step("t4_withdraw");
        // forced release at MAX_HOLD
        bus.req = 8'h04;
        for (int i = 0; i < MH; i++) begin
            step("t5_hold");
            chk("t5_hold_grant", 32'(bus.grant), 32'h04);
        end
        step("t5_to");
        chk("t5_timeout1", 32'(bus.timeout), 32'd1);
        chk("t5_idle", 32'(bus.grant), 32'h0);
        step("t5_regrant");
        chk("t5_regrant04", 32'(bus.grant), 32'h04);
        chk("t5_timeout0", 32'(bus.timeout), 32'd0);
        // done coincides with the final hold cycle: no timeout
        step("t6_c2");
        step("t6_c3");
        step("t6_c4");
        bus.done = 1'b1;
        step("t6_done_rel");
        chk("t6_done_to", 32'(bus.timeout), 32'd0);
        chk("t6_done_idle", 32'(bus.busy), 32'd0);
        bus.done = 1'b0;
        step("t6_g");
        step("t6_c2b");
        bus.req = '0;
        step("t6_wd_rel");
        chk("t6_wd_to", 32'(bus.timeout), 32'd0);
        chk("t6_wd_idle", 32'(bus.grant), 32'h0);
        // random traffic, done ignored while idle
        for (int i = 0; i < 400; i++) begin
            bus.req = 8'($urandom) & 8'($urandom);
            bus.done = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
